// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and helpers for the PS/2 keyboard decoder.
package ps2_pkg;

   localparam logic [7:0] SC_EXT_PREFIX   = 8'hE0;
   localparam logic [7:0] SC_BREAK_PREFIX = 8'hF0;

   localparam int unsigned NUM_IGNORED = 5;
   localparam logic [7:0] SC_IGNORED [NUM_IGNORED] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hE1};

   typedef logic [0:0] rx_state_t;
   localparam rx_state_t RX_IDLE  = 1'b0;
   localparam rx_state_t RX_SHIFT = 1'b1;

   typedef logic [1:0] sc_state_t;
   localparam sc_state_t SC_IDLE    = 2'd0;
   localparam sc_state_t SC_EXT     = 2'd1;
   localparam sc_state_t SC_BRK     = 2'd2;
   localparam sc_state_t SC_EXT_BRK = 2'd3;

   // Keyboard status/ack bytes that carry no key information in the idle state.
   function automatic logic isIgnored(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < NUM_IGNORED; i++) begin
         if (code == SC_IGNORED[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 input conditioning and 11-bit frame receiver with watchdog.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byteValid,
   output logic [7:0] byteOut,
   output logic       frameError
);

   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYCLES);

   logic [1:0]    clkSync;
   logic [1:0]    dataSync;
   logic [FW-1:0] filtCnt;
   logic          filtClk;
   logic          filtPrev;
   logic          fall;
   logic [WW-1:0] wdCnt;
   rx_state_t     rxState;
   logic [3:0]    bitCnt;
   logic [8:0]    shiftReg;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         clkSync  <= '1;
         dataSync <= '1;
      end else begin
         clkSync  <= {clkSync[0], ps2_clk};
         dataSync <= {dataSync[0], ps2_data};
      end
   end

   // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         filtCnt  <= '0;
         filtClk  <= 1'b1;
         filtPrev <= 1'b1;
      end else begin
         filtPrev <= filtClk;
         if (clkSync[1] == filtClk) begin
            filtCnt <= '0;
         end else if (filtCnt == FILT_LAST) begin
            filtCnt <= '0;
            filtClk <= clkSync[1];
         end else begin
            filtCnt <= filtCnt + 1'b1;
         end
      end
   end

   assign fall = filtPrev & ~filtClk;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wdCnt <= '0;
      end else if (fall) begin
         wdCnt <= '0;
      end else if (wdCnt != WD_MAX) begin
         wdCnt <= wdCnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rxState    <= RX_IDLE;
         bitCnt     <= '0;
         shiftReg   <= '0;
         byteValid  <= 1'b0;
         byteOut    <= '0;
         frameError <= 1'b0;
      end else begin
         byteValid  <= 1'b0;
         frameError <= 1'b0;
         case (rxState)
            RX_IDLE: begin
               if (fall) begin
                  if (!dataSync[1]) begin
                     rxState <= RX_SHIFT;
                     bitCnt  <= '0;
                  end else begin
                     frameError <= 1'b1;
                  end
               end
            end
            RX_SHIFT: begin
               // A fall in the same cycle as the timeout takes priority.
               if (fall) begin
                  if (bitCnt == 4'd9) begin
                     rxState <= RX_IDLE;
                     byteOut <= shiftReg[7:0];
                     if ((^shiftReg) && dataSync[1]) byteValid  <= 1'b1;
                     else                            frameError <= 1'b1;
                  end else begin
                     shiftReg <= {dataSync[1], shiftReg[8:1]};
                     bitCnt   <= bitCnt + 1'b1;
                  end
               end else if (wdCnt == WD_MAX) begin
                  rxState    <= RX_IDLE;
                  frameError <= 1'b1;
               end
            end
            default: rxState <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 keyboard scan-code decoder: frames bytes and emits {ext, byte} make/brake pulses.
module ps2_keyboard_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned KEYCODE_WIDTH  = 9,
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   output logic [KEYCODE_WIDTH-1:0] keyCode,
   output logic                     make,
   output logic                     brake,
   output logic                     frameError
);

   logic       byteValid;
   logic [7:0] byteOut;
   sc_state_t  scState;

   ps2_frame_rx #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_frameRx (
      .clk       (clk),
      .resetN    (resetN),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .byteValid (byteValid),
      .byteOut   (byteOut),
      .frameError(frameError)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         scState <= SC_IDLE;
         keyCode <= '0;
         make    <= 1'b0;
         brake   <= 1'b0;
      end else begin
         make  <= 1'b0;
         brake <= 1'b0;
         if (frameError) begin
            scState <= SC_IDLE;
         end else if (byteValid) begin
            case (scState)
               SC_IDLE: begin
                  if (byteOut == SC_EXT_PREFIX)        scState <= SC_EXT;
                  else if (byteOut == SC_BREAK_PREFIX) scState <= SC_BRK;
                  else if (!isIgnored(byteOut)) begin
                     keyCode <= KEYCODE_WIDTH'({1'b0, byteOut});
                     make    <= 1'b1;
                  end
               end
               SC_EXT: begin
                  if (byteOut == SC_BREAK_PREFIX) scState <= SC_EXT_BRK;
                  else if (byteOut != SC_EXT_PREFIX) begin
                     keyCode <= KEYCODE_WIDTH'({1'b1, byteOut});
                     make    <= 1'b1;
                     scState <= SC_IDLE;
                  end
               end
               SC_BRK: begin
                  keyCode <= KEYCODE_WIDTH'({1'b0, byteOut});
                  brake   <= 1'b1;
                  scState <= SC_IDLE;
               end
               SC_EXT_BRK: begin
                  keyCode <= KEYCODE_WIDTH'({1'b1, byteOut});
                  brake   <= 1'b1;
                  scState <= SC_IDLE;
               end
               default: scState <= SC_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Scoreboard bench for ps2_keyboard_decoder: directed frames, queued expectations, event monitor.
module tb_ps2_keyboard_decoder;

   localparam int HALF = 20;     // clk cycles per PS/2 half period
   localparam int TMO  = 1000;

   typedef struct {
      int         kind;          // 0 make, 1 brake, 2 frame error
      logic [8:0] code;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       ps2Clk = 1'b1;
   logic       ps2Data = 1'b1;
   logic [8:0] keyCode;
   logic       make, brake, frameError;

   exp_t expQ[$];
   int   nCmp = 0;
   int   nErr = 0;

   ps2_keyboard_decoder #(
      .KEYCODE_WIDTH (9),
      .FILTER_LEN    (8),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk       (clk),
      .resetN    (resetN),
      .ps2_clk   (ps2Clk),
      .ps2_data  (ps2Data),
      .keyCode   (keyCode),
      .make      (make),
      .brake     (brake),
      .frameError(frameError)
   );

   always #5 clk = ~clk;

   task automatic waitCyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendBits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2Data = bits[i];
         waitCyc(HALF);
         ps2Clk = 1'b0;
         waitCyc(HALF);
         ps2Clk = 1'b1;
      end
      waitCyc(HALF);
   endtask

   task automatic sendFrame(input logic [7:0] data, input logic badParity);
      logic par;
      par = ~(^data) ^ badParity;
      sendBits({1'b1, par, data, 1'b0}, 11);
   endtask

   task automatic expectEv(input int kind, input logic [8:0] code);
      exp_t e;
      e.kind = kind;
      e.code = code;
      expQ.push_back(e);
   endtask

   task automatic checkVal(input string name, input logic [8:0] act, input logic [8:0] req);
      nCmp++;
      if (act !== req) begin
         nErr++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkVal({tag, "_keyCode"}, keyCode, 9'h000);
      checkVal({tag, "_make"}, {8'h0, make}, 9'h000);
      checkVal({tag, "_brake"}, {8'h0, brake}, 9'h000);
      checkVal({tag, "_frameError"}, {8'h0, frameError}, 9'h000);
   endtask

   // Monitor: every output event pops one expectation.
   always @(negedge clk) begin
      if (resetN && (make || brake || frameError)) begin
         int   kind;
         exp_t e;
         kind = frameError ? 2 : (brake ? 1 : 0);
         nCmp++;
         if ((make && brake) || (frameError && (make || brake))) begin
            nErr++;
            $display("FAIL exclusive: make=%b brake=%b frameError=%b", make, brake, frameError);
         end else if (expQ.size() == 0) begin
            nErr++;
            $display("FAIL unexpected_event: got kind %0d code %h, expected none", kind, keyCode);
         end else begin
            e = expQ.pop_front();
            if (kind != e.kind || (kind != 2 && keyCode !== e.code)) begin
               nErr++;
               $display("FAIL event: got kind %0d code %h, expected kind %0d code %h",
                        kind, keyCode, e.kind, e.code);
            end
         end
      end
   end

   initial begin
      waitCyc(5);
      checkIdleOutputs("reset");
      resetN = 1'b1;
      waitCyc(20);

      expectEv(0, 9'h075);
      sendFrame(8'h75, 1'b0);

      expectEv(1, 9'h075);
      sendFrame(8'hF0, 1'b0);
      sendFrame(8'h75, 1'b0);

      expectEv(0, 9'h16B);
      sendFrame(8'hE0, 1'b0);
      sendFrame(8'h6B, 1'b0);
      expectEv(1, 9'h16B);
      sendFrame(8'hE0, 1'b0);
      sendFrame(8'hF0, 1'b0);
      sendFrame(8'h6B, 1'b0);

      expectEv(2, 9'h000);
      sendFrame(8'h74, 1'b1);
      expectEv(0, 9'h074);
      sendFrame(8'h74, 1'b0);

      // Start bit plus 5 data bits of 0x73, then silence past the watchdog.
      expectEv(2, 9'h000);
      sendBits({5'b00000, 5'b10011, 1'b0}, 6);
      waitCyc(TMO + 200);
      expectEv(0, 9'h073);
      sendFrame(8'h73, 1'b0);

      // Extended prefix plus a partial frame, then reset.
      sendFrame(8'hE0, 1'b0);
      sendBits({5'b00000, 5'b01011, 1'b0}, 5);
      resetN = 1'b0;
      #1;
      checkIdleOutputs("midreset");
      waitCyc(5);
      resetN = 1'b1;
      waitCyc(20);
      expectEv(0, 9'h06B);
      sendFrame(8'h6B, 1'b0);

      waitCyc(200);
      nCmp++;
      if (expQ.size() != 0) begin
         nErr++;
         $display("FAIL drain: got %0d pending events, expected 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
